// File: rtl/regfile_pkg.sv
// ---------------------------------------------------------------------
// regfile_pkg : shared op codes, sizes and operand-usage helpers. Rev 1.0
// ---------------------------------------------------------------------
`default_nettype none

package regfile_pkg;
   localparam int NREGS = 4;
   localparam int W     = 16;
   localparam int AW    = 3;

   localparam logic [AW-1:0] NREGS_A = AW'(NREGS);

   localparam logic [2:0] OP_ADD  = 3'd0;
   localparam logic [2:0] OP_SUB  = 3'd1;
   localparam logic [2:0] OP_AND  = 3'd2;
   localparam logic [2:0] OP_OR   = 3'd3;
   localparam logic [2:0] OP_XOR  = 3'd4;
   localparam logic [2:0] OP_LI   = 3'd5;
   localparam logic [2:0] OP_ADDI = 3'd6;
   localparam logic [2:0] OP_MOV  = 3'd7;

   function automatic logic uses_a(input logic [2:0] op);
      return op != OP_LI;
   endfunction

   function automatic logic uses_b(input logic [2:0] op);
      return op <= OP_XOR;
   endfunction

   function automatic logic addr_ok(input logic [AW-1:0] a);
      return a < NREGS_A;
   endfunction
endpackage

`default_nettype wire

// File: rtl/regfile_alu_issue_alu.sv
// ---------------------------------------------------------------------
// regfile_alu_issue_alu : combinational ALU, results modulo 2^W. Rev 1.0
// ---------------------------------------------------------------------
`default_nettype none

module regfile_alu_issue_alu
   import regfile_pkg::*;
(
   input  logic [2:0]   op_code,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic [W-1:0] imm,
   output logic [W-1:0] result
);

   always_comb begin
      result = '0;
      case (op_code)
         OP_ADD:  result = a + b;
         OP_SUB:  result = a - b;
         OP_AND:  result = a & b;
         OP_OR:   result = a | b;
         OP_XOR:  result = a ^ b;
         OP_LI:   result = imm;
         OP_ADDI: result = a + imm;
         OP_MOV:  result = a;
         default: result = '0;
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/regfile_alu_issue.sv
// ---------------------------------------------------------------------
// regfile_alu_issue : ALU issue + registered write-back to a 4x16 register
// file; REGFILE_ALU_ISSUE_FORWARD_EN selects forwarding instead of a stall. Rev 1.0
// ---------------------------------------------------------------------
`default_nettype none

module regfile_alu_issue
   import regfile_pkg::*;
(
   input  logic          clk,
   input  logic          reset,
   input  logic          op_valid,
   output logic          op_ready,
   input  logic [2:0]    op_code,
   input  logic [2:0]    op_rd,
   input  logic [2:0]    op_rs,
   input  logic [2:0]    op_rt,
   input  logic [W-1:0]  op_imm,
   output logic [2:0]    rf_raA,
   input  logic [W-1:0]  rf_rdA,
   output logic [2:0]    rf_raB,
   input  logic [W-1:0]  rf_rdB,
   output logic          rf_w,
   output logic [2:0]    rf_wa,
   output logic [W-1:0]  rf_wd,
   output logic          res_valid,
   output logic [W-1:0]  res_data,
   output logic          op_err,
   output logic [15:0]   retired
);

   logic         wb_w;
   logic         use_a;
   logic         use_b;
   logic         rs_ok;
   logic         rt_ok;
   logic         rd_ok;
   logic         hz_a;
   logic         hz_b;
   logic         accept;
   logic         err;
   logic [W-1:0] opnd_a;
   logic [W-1:0] opnd_b;
   logic [W-1:0] alu_res;

   assign rf_raA = op_rs;
   assign rf_raB = op_rt;

   assign use_a = uses_a(op_code);
   assign use_b = uses_b(op_code);
   assign rs_ok = addr_ok(op_rs);
   assign rt_ok = addr_ok(op_rt);
   assign rd_ok = addr_ok(op_rd);

   // wb_w already implies rf_wa is an implemented register
   assign hz_a = wb_w && use_a && (op_rs == rf_wa);
   assign hz_b = wb_w && use_b && (op_rt == rf_wa);

`ifdef REGFILE_ALU_ISSUE_FORWARD_EN
   assign opnd_a   = hz_a ? rf_wd : (rs_ok ? rf_rdA : '0);
   assign opnd_b   = hz_b ? rf_wd : (rt_ok ? rf_rdB : '0);
   assign op_ready = !reset;
`else
   assign opnd_a   = rs_ok ? rf_rdA : '0;
   assign opnd_b   = rt_ok ? rf_rdB : '0;
   assign op_ready = !reset && !(hz_a || hz_b);
`endif

   assign accept = op_valid && op_ready;
   assign err    = !rd_ok || (use_a && !rs_ok) || (use_b && !rt_ok);

   regfile_alu_issue_alu u_alu (
      .op_code (op_code),
      .a       (opnd_a),
      .b       (opnd_b),
      .imm     (op_imm),
      .result  (alu_res)
   );

   // a reset arriving during the write-back cycle must block the commit
   assign rf_w = wb_w && !reset;

   always_ff @(posedge clk) begin
      if (reset) begin
         wb_w      <= 1'b0;
         rf_wa     <= '0;
         rf_wd     <= '0;
         res_valid <= 1'b0;
         res_data  <= '0;
         op_err    <= 1'b0;
         retired   <= '0;
      end else begin
         wb_w      <= accept && (op_code != OP_MOV) && rd_ok;
         res_valid <= accept;
         op_err    <= accept && err;
         if (accept) begin
            rf_wa    <= op_rd;
            rf_wd    <= alu_res;
            res_data <= alu_res;
            retired  <= retired + 16'd1;
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_regfile_alu_issue.sv
// ---------------------------------------------------------------------
// tb_regfile_alu_issue : randomized bench with architectural reference model. Rev 1.0
// ---------------------------------------------------------------------
`default_nettype none

module tb_regfile_alu_issue;
   logic        clk = 1'b0;
   logic        reset;
   logic        op_valid;
   logic        op_ready;
   logic [2:0]  op_code, op_rd, op_rs, op_rt;
   logic [15:0] op_imm;
   logic [2:0]  rf_raA, rf_raB, rf_wa;
   logic [15:0] rf_rdA, rf_rdB, rf_wd;
   logic        rf_w, res_valid, op_err;
   logic [15:0] res_data, retired;

   regfile_alu_issue dut (
      .clk(clk), .reset(reset), .op_valid(op_valid), .op_ready(op_ready),
      .op_code(op_code), .op_rd(op_rd), .op_rs(op_rs), .op_rt(op_rt), .op_imm(op_imm),
      .rf_raA(rf_raA), .rf_rdA(rf_rdA), .rf_raB(rf_raB), .rf_rdB(rf_rdB),
      .rf_w(rf_w), .rf_wa(rf_wa), .rf_wd(rf_wd),
      .res_valid(res_valid), .res_data(res_data), .op_err(op_err), .retired(retired)
   );

   always #5 clk = ~clk;

   // Register file the block talks to; out-of-range reads return junk
   logic [15:0] rf_mem [0:3];
   assign rf_rdA = (rf_raA < 3'd4) ? rf_mem[rf_raA[1:0]] : 16'hDEAD;
   assign rf_rdB = (rf_raB < 3'd4) ? rf_mem[rf_raB[1:0]] : 16'hBEEF;
   always @(posedge clk) if (rf_w) rf_mem[rf_wa[1:0]] <= rf_wd;

   // Architectural reference state: registers updated the moment an op issues
   logic [15:0] ref_regs [0:3];
   logic [15:0] exp_ret;
   logic        prev_wr;
   logic [2:0]  prev_rd;

   int errors = 0;
   int checks = 0;

   logic        exp_valid, exp_w, exp_err;
   logic [15:0] exp_data, exp_wd;
   logic [2:0]  exp_wa;
   int          exp_stalls;
   logic        obs_valid, obs_w, obs_err, obs_ra_ok;
   logic [15:0] obs_data, obs_wd, obs_ret;
   logic [2:0]  obs_wa;
   int          obs_stalls;

   function automatic logic [37:0] obs_vec();
      return {obs_valid, obs_data, obs_w, obs_err,
              exp_w ? obs_wa : 3'd0, exp_w ? obs_wd : 16'd0};
   endfunction

   function automatic logic [37:0] exp_vec();
      return {exp_valid, exp_data, exp_w, exp_err,
              exp_w ? exp_wa : 3'd0, exp_w ? exp_wd : 16'd0};
   endfunction

   task automatic issue(input logic [2:0] op, input logic [2:0] rd, input logic [2:0] rs,
                        input logic [2:0] rt, input logic [15:0] imm);
      logic [15:0] a, b, r;
      logic ua, ub;
      int n;
      ua = (op != 3'd5);
      ub = (op <= 3'd4);
      a = (rs < 3'd4) ? ref_regs[rs[1:0]] : 16'h0000;
      b = (rt < 3'd4) ? ref_regs[rt[1:0]] : 16'h0000;
      case (op)
         3'd0: r = a + b;
         3'd1: r = a - b;
         3'd2: r = a & b;
         3'd3: r = a | b;
         3'd4: r = a ^ b;
         3'd5: r = imm;
         3'd6: r = a + imm;
         default: r = a;
      endcase
      exp_valid = 1'b1;
      exp_data  = r;
      exp_w     = (op != 3'd7) && (rd < 3'd4);
      exp_wa    = rd;
      exp_wd    = r;
      exp_err   = (rd >= 3'd4) || (ua && rs >= 3'd4) || (ub && rt >= 3'd4);
      exp_ret   = exp_ret + 16'd1;
`ifdef REGFILE_ALU_ISSUE_FORWARD_EN
      exp_stalls = 0;
`else
      exp_stalls = (prev_wr && ((ua && rs == prev_rd) || (ub && rt == prev_rd))) ? 1 : 0;
`endif
      op_valid = 1'b1; op_code = op; op_rd = rd; op_rs = rs; op_rt = rt; op_imm = imm;
      n = 0;
      @(negedge clk);
      obs_ra_ok = (rf_raA === rs) && (rf_raB === rt);
      while (op_ready !== 1'b1 && n < 4) begin
         n++;
         @(negedge clk);
      end
      obs_stalls = n;
      @(posedge clk);
      #1;
      obs_valid = res_valid; obs_data = res_data; obs_w = rf_w; obs_wa = rf_wa;
      obs_wd = rf_wd; obs_err = op_err; obs_ret = retired;
      if (exp_w) ref_regs[rd[1:0]] = r;
      prev_wr = exp_w;
      prev_rd = rd;
   endtask

   task automatic idle();
      op_valid = 1'b0;
      @(posedge clk);
      #1;
      prev_wr = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1; op_valid = 1'b0; op_code = '0; op_rd = '0; op_rs = '0; op_rt = '0; op_imm = '0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({rf_w, rf_wa, rf_wd, res_valid, res_data, op_err, retired} !== 55'd0) begin
         errors++;
         $display("FAIL reset_outputs: got w=%b wa=%h wd=%h rv=%b rd=%h err=%b ret=%h, expected all zero",
                  rf_w, rf_wa, rf_wd, res_valid, res_data, op_err, retired);
      end
      reset = 1'b0;
      exp_ret = 16'd0; prev_wr = 1'b0; prev_rd = 3'd0;
      @(negedge clk);
      checks++;
      if (op_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_ready: got %b expected 1", op_ready);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_li();
      logic [15:0] vals [0:3];
      vals[0] = 16'h0001; vals[1] = 16'h0002; vals[2] = 16'h00FF; vals[3] = 16'hFFFF;
      for (int i = 0; i < 4; i++) begin
         issue(3'd5, 3'(i), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), vals[i]);
         checks++;
         if (obs_vec() !== exp_vec() || obs_wd !== vals[i] || obs_w !== 1'b1) begin
            errors++;
            $display("FAIL li_r%0d: got %h wd=%h expected %h wd=%h", i, obs_vec(), obs_wd, exp_vec(), vals[i]);
         end
      end
      checks++;
      if (obs_ret !== 16'd4) begin
         errors++;
         $display("FAIL li_retired: got %0d expected 4", obs_ret);
      end
   endtask

   task automatic test_add_wrap();
      idle();
      issue(3'd0, 3'd1, 3'd3, 3'd0, 16'h0);
      checks++;
      if (obs_vec() !== exp_vec() || obs_data !== 16'h0000 || obs_valid !== 1'b1) begin
         errors++;
         $display("FAIL add_wrap: got %h data=%h expected %h data=0000", obs_vec(), obs_data, exp_vec());
      end
      idle();
      checks++;
      if (res_valid !== 1'b0 || rf_w !== 1'b0 || rf_wa !== 3'd1 || rf_wd !== 16'h0000) begin
         errors++;
         $display("FAIL add_wrap_idle: got rv=%b w=%b wa=%h wd=%h expected 0 0 1 0000",
                  res_valid, rf_w, rf_wa, rf_wd);
      end
   endtask

   task automatic test_back_to_back();
      int want;
`ifdef REGFILE_ALU_ISSUE_FORWARD_EN
      want = 0;
`else
      want = 1;
`endif
      issue(3'd5, 3'd2, 3'd0, 3'd0, 16'h1234);
      issue(3'd0, 3'd1, 3'd2, 3'd2, 16'h0);
      checks++;
      if (obs_stalls != want) begin
         errors++;
         $display("FAIL b2b_bubbles: got %0d expected %0d", obs_stalls, want);
      end
      checks++;
      if (obs_vec() !== exp_vec() || obs_wd !== 16'h2468) begin
         errors++;
         $display("FAIL b2b_result: got %h wd=%h expected %h wd=2468", obs_vec(), obs_wd, exp_vec());
      end
      idle();
   endtask

   task automatic test_errors();
      issue(3'd0, 3'd5, 3'd0, 3'd1, 16'h0);
      checks++;
      if ({obs_err, obs_w, obs_valid} !== 3'b101 || obs_vec() !== exp_vec()) begin
         errors++;
         $display("FAIL err_rd: got err=%b w=%b rv=%b expected 1 0 1", obs_err, obs_w, obs_valid);
      end
      issue(3'd7, 3'd0, 3'd6, 3'd0, 16'h0);
      checks++;
      if ({obs_err, obs_data, obs_w} !== {1'b1, 16'h0000, 1'b0} || obs_vec() !== exp_vec()) begin
         errors++;
         $display("FAIL err_mov_r6: got err=%b data=%h w=%b expected 1 0000 0", obs_err, obs_data, obs_w);
      end
      idle();
   endtask

   task automatic test_sub_mov();
      issue(3'd5, 3'd0, 3'd0, 3'd0, 16'h0001);
      issue(3'd5, 3'd3, 3'd0, 3'd0, 16'hFFFF);
      issue(3'd1, 3'd0, 3'd0, 3'd3, 16'h0);
      checks++;
      if (obs_vec() !== exp_vec() || obs_wd !== 16'h0002) begin
         errors++;
         $display("FAIL sub: got %h wd=%h expected %h wd=0002", obs_vec(), obs_wd, exp_vec());
      end
      issue(3'd7, 3'd1, 3'd3, 3'd0, 16'h0);
      checks++;
      if (obs_data !== 16'hFFFF || obs_w !== 1'b0 || obs_err !== 1'b0 || obs_vec() !== exp_vec()) begin
         errors++;
         $display("FAIL mov_r3: got data=%h w=%b err=%b expected FFFF 0 0", obs_data, obs_w, obs_err);
      end
      idle();
   endtask

   task automatic test_random();
      logic [2:0] op, rd, rs, rt;
      logic [2:0]  held_wa;
      logic [15:0] held_wd;
      for (int i = 0; i < 150; i++) begin
         if ($urandom_range(0, 3) == 0) begin
            held_wa = rf_wa;
            held_wd = rf_wd;
            idle();
            checks++;
            if (res_valid !== 1'b0 || rf_w !== 1'b0 || rf_wa !== held_wa || rf_wd !== held_wd) begin
               errors++;
               $display("FAIL rnd_idle %0d: got rv=%b w=%b wa=%h wd=%h expected 0 0 %h %h",
                        i, res_valid, rf_w, rf_wa, rf_wd, held_wa, held_wd);
            end
         end
         op = 3'($urandom_range(0, 7));
         rd = 3'($urandom_range(0, 4));
         rs = 3'($urandom_range(0, 4));
         rt = 3'($urandom_range(0, 4));
         if ($urandom_range(0, 1) == 0) rs = prev_rd;
         if ($urandom_range(0, 2) == 0) rt = prev_rd;
         issue(op, rd, rs, rt, 16'($urandom));
         checks++;
         if (obs_vec() !== exp_vec() || obs_ret !== exp_ret || obs_stalls != exp_stalls || !obs_ra_ok) begin
            errors++;
            $display("FAIL rnd %0d op=%0d: got %h ret=%h stalls=%0d ra_ok=%b expected %h ret=%h stalls=%0d",
                     i, op, obs_vec(), obs_ret, obs_stalls, obs_ra_ok, exp_vec(), exp_ret, exp_stalls);
         end
      end
      idle();
      checks++;
      for (int k = 0; k < 4; k++) begin
         if (rf_mem[k] !== ref_regs[k]) begin
            errors++;
            $display("FAIL rnd_regs r%0d: got %h expected %h", k, rf_mem[k], ref_regs[k]);
            break;
         end
      end
   endtask

   task automatic test_reset_mid();
      logic [15:0] saved;
      saved = ref_regs[1];
      if (saved == 16'hAAAA) begin
         issue(3'd5, 3'd1, 3'd0, 3'd0, 16'h5555);
         idle();
         saved = ref_regs[1];
      end
      issue(3'd5, 3'd1, 3'd0, 3'd0, 16'hAAAA);
      checks++;
      if (obs_w !== 1'b1 || obs_wd !== 16'hAAAA) begin
         errors++;
         $display("FAIL rstmid_pending: got w=%b wd=%h expected 1 AAAA", obs_w, obs_wd);
      end
      reset = 1'b1;
      op_valid = 1'b0;
      @(posedge clk);
      #1;
      ref_regs[1] = saved;
      checks++;
      if (rf_mem[1] !== saved) begin
         errors++;
         $display("FAIL rstmid_r1: got %h expected %h", rf_mem[1], saved);
      end
      checks++;
      if ({rf_w, rf_wa, rf_wd, res_valid, res_data, op_err, retired} !== 55'd0) begin
         errors++;
         $display("FAIL rstmid_outputs: got w=%b wa=%h wd=%h rv=%b rd=%h err=%b ret=%h, expected all zero",
                  rf_w, rf_wa, rf_wd, res_valid, res_data, op_err, retired);
      end
      reset = 1'b0;
      exp_ret = 16'd0; prev_wr = 1'b0;
      @(posedge clk);
      #1;
      issue(3'd6, 3'd2, 3'd1, 3'd0, 16'h0010);
      checks++;
      if (obs_vec() !== exp_vec() || obs_ret !== 16'd1) begin
         errors++;
         $display("FAIL rstmid_after: got %h ret=%h expected %h ret=0001", obs_vec(), obs_ret, exp_vec());
      end
      idle();
   endtask

   initial begin
      for (int k = 0; k < 4; k++) begin
         rf_mem[k] = 16'h0000;
         ref_regs[k] = 16'h0000;
      end
      test_reset();
      test_li();
      test_add_wrap();
      test_back_to_back();
      test_errors();
      test_sub_mov();
      test_random();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL timeout: simulation did not complete, errors=%0d checks=%0d", errors, checks);
      $fatal(1, "timeout");
   end

endmodule

`default_nettype wire

// File: doc/regfile_alu_issue.md
Name: regfile_alu_issue

Overview:
Initiator side of the 4x16 register file port set: accepts ALU micro-ops over a valid/ready handshake and drives the register file's two read ports and single write port. Issues at most one op per cycle, computes the result, and writes it back one cycle later (registered write-back stage). Sits between the decode/sequencer logic and the register file in the datapath.

Parameters:
NREGS, 4, number of implemented registers; addresses >= NREGS are out of range
W, 16, data width

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  synchronous active-high reset
op_valid  in  1  micro-op present
op_ready  out  1  block accepts op this cycle
op_code  in  3  operation (see Behaviour)
op_rd  in  3  destination register
op_rs  in  3  source A register
op_rt  in  3  source B register
op_imm  in  W  immediate
rf_raA  out  3  register file read address A
rf_rdA  in  W  register file read data A (combinational)
rf_raB  out  3  register file read address B
rf_rdB  in  W  register file read data B (combinational)
rf_w  out  1  register file write enable
rf_wa  out  3  register file write address
rf_wd  out  W  register file write data
res_valid  out  1  result strobe, one cycle
res_data  out  W  result value
op_err  out  1  one-cycle strobe: accepted op had out-of-range address
retired  out  16  count of accepted ops, wraps 0xFFFF->0

Behaviour:
- Reset: rf_w=0, rf_wa=0, rf_wd=0, res_valid=0, res_data=0, op_err=0, retired=0, WB stage empty; op_ready=1 from the first cycle after reset. Register file contents are not reset.
- Accept when op_valid && op_ready. rf_raA=op_rs, rf_raB=op_rt, driven combinationally every cycle.
- op_code: 0 ADD A+B; 1 SUB A-B; 2 AND; 3 OR; 4 XOR; 5 LI imm; 6 ADDI A+imm; 7 MOV A (read-only, no write-back). Arithmetic is modulo 2^W, no carry/overflow out.
- Operand read: source register >= NREGS reads 0.
- Cycle N accept -> cycle N+1: WB register holds result; rf_w=1 (except op 7), rf_wa=op_rd, rf_wd=result; res_valid=1, res_data=result. The register file commits at end of cycle N+1.
- op_rd >= NREGS: rf_w=0, op_err=1 in N+1, res_valid still 1. op_rs/op_rt >= NREGS (for ops that use them) also set op_err.
- Hazard: op accepted in N+1 whose rs/rt equals the WB stage rd (WB writing, rd < NREGS) sees stale register file data; resolved per Optional Feature.
- retired increments on every accept, including error ops.
- Reset asserted mid-operation: WB stage discarded, pending write never reaches the register file.
- No accept in a cycle: rf_w=0, res_valid=0 next cycle; rf_wa/rf_wd hold their last values.

Optional Feature:
REGFILE_ALU_ISSUE_FORWARD_EN
- Defined: WB result is forwarded to operand A/B on address match; op_ready is tied 1 after reset; dependent back-to-back ops run at one per cycle.
- Undefined: on a hazard, op_ready=0 for that cycle (op not accepted, must be held by the producer); accepted the next cycle once the write has committed. Exactly one bubble per hazard.

Decomposition:
- Shared package regfile_pkg: op_code constants (OP_ADD..OP_MOV), NREGS, W, address width 3.
- One sub-module: regfile_alu_issue_alu (combinational op_code/A/B/imm -> result); everything else stays in the top.

Test Plan:
- LI r0..r3 with 0x0001,0x0002,0x00FF,0xFFFF -> rf_w writes exactly those values one cycle after each accept; retired=4.
- ADD r1=r3+r0 (0xFFFF+0x0001) -> rf_wd=0x0000 (wrap), res_valid one cycle.
- Back-to-back LI r2=0x1234 then XOR r1=r2^r2... use ADD r1=r2+r2 -> FORWARD_EN: r1=0x2468, no bubble; without it: op_ready low one cycle, r1=0x2468.
- ADD r5=r0+r1 -> op_err=1, rf_w=0, res_valid=1; MOV from r6 -> res_data=0x0000, op_err=1.
- SUB r0=r0-r3 with r0=1, r3=0xFFFF -> 0x0002; MOV r3 -> res_data=0xFFFF, rf_w=0.
- Assert reset during cycle after an accepted LI r1=0xAAAA -> no write to r1, all outputs at reset values, retired=0.
